// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INCR          = 4;
  localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer used when decode stalls while a
// fetch response is arriving. Flush wins over load, load wins over unload.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            flush,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic            full
);

  // Occupancy flag: the only control state in the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // Payload capture; contents are meaningless while full is low.
  always_ff @(posedge clk) begin
    if (load) begin
      instr_out <= instr_in;
      pc_out    <= pc_in;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: drives PC_Next for an external PC register
// that loads every cycle, keeps one memory read in flight at most, and
// hands instruction/PC pairs to decode through a registered output plus a
// one-entry skid buffer. Branch/jump redirects cancel in-flight work.
// Optional build macro FETCH_ALIGN_CHECK_EN: flags misaligned redirect
// targets on fetch_misalign and forces the target's low two bits to zero.
module if_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PC_Next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic            valid_d,
  output logic            fetch_misalign
);

  localparam logic [XLEN-1:0] INCR = XLEN'(PC_INCR);

  function automatic logic [XLEN-1:0] redirect_target(input logic [XLEN-1:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
    return {t[XLEN-1:2], 2'b00};
`else
    return t;
`endif
  endfunction

  fetch_state_t    state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] pc_next_c;
  logic            redir;
  logic            ld_req_pc, ld_out_mem, ld_out_skid, clr_out;
  logic            skid_load, skid_unload, skid_flush;
  logic [XLEN-1:0] skid_instr, skid_pc;
  logic            skid_full;

  assign redir     = redirect_valid && (state_q != IDLE);
  assign imem_req  = (state_q == REQ);
  assign imem_addr = PC;
  // The PC register is reset alongside us, so hold it at RESET_PC meanwhile.
  assign PC_Next   = rst ? pc_next_c : RESET_PC;

  // State and drop-flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, next-PC and datapath load decisions; redirect overrides last.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    pc_next_c   = PC;
    ld_req_pc   = 1'b0;
    ld_out_mem  = 1'b0;
    ld_out_skid = 1'b0;
    clr_out     = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          ld_req_pc = 1'b1;
          pc_next_c = PC + INCR;
          state_d   = WAIT;
          if (redir) drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (redir) begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!valid_d || !stall) begin
            ld_out_mem = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_d   = FULL;
          end
        end
      end
      FULL: begin
        if (redir) begin
          state_d = REQ;
        end else if (!stall) begin
          ld_out_skid = 1'b1;
          skid_unload = 1'b1;
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redir) begin
      pc_next_c  = redirect_target(redirect_pc);
      clr_out    = 1'b1;
      skid_flush = 1'b1;
    end
  end

  // Address of the outstanding request, tagged onto its response.
  always_ff @(posedge clk) begin
    if (ld_req_pc) req_pc <= PC;
  end

  // Decode-facing output register: redirect clears, stall holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d <= 1'b0;
      InstrD  <= '0;
      PCD     <= '0;
    end else if (clr_out) begin
      valid_d <= 1'b0;
    end else if (ld_out_mem) begin
      valid_d <= 1'b1;
      InstrD  <= imem_rdata;
      PCD     <= req_pc;
    end else if (ld_out_skid) begin
      valid_d <= 1'b1;
      InstrD  <= skid_instr;
      PCD     <= skid_pc;
    end else if (!stall) begin
      valid_d <= 1'b0;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .flush     (skid_flush),
    .instr_in  (imem_rdata),
    .pc_in     (req_pc),
    .instr_out (skid_instr),
    .pc_out    (skid_pc),
    .full      (skid_full)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  // One-cycle pulse when a redirect target is not word aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_misalign <= 1'b0;
    end else begin
      fetch_misalign <= redir && (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign fetch_misalign = 1'b0;
`endif

  // skid_full mirrors the FULL state; kept visible for debug only.
  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a behavioural PC register that
// loads PC_Next every cycle. Honours FETCH_ALIGN_CHECK_EN if defined.
module tb_if_fetch_ctrl;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] REDIR_B = 32'h0000_0102;
  localparam logic [31:0] MIS_EXP = 32'd1;
`else
  localparam logic [31:0] REDIR_B = 32'h0000_0100;
  localparam logic [31:0] MIS_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc, pc_next, imem_addr, imem_rdata, redirect_pc, instr_d, pc_d;
  logic        imem_req, imem_gnt, imem_rvalid, redirect_valid, stall;
  logic        valid_d, fetch_misalign;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  // PC register on the far side of the interface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 32'h0;
    else      pc <= pc_next;
  end

  if_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (pc),
    .PC_Next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .InstrD         (instr_d),
    .PCD            (pc_d),
    .valid_d        (valid_d),
    .fetch_misalign (fetch_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; stall = 0;
    redirect_valid = 1; redirect_pc = 32'h55;
    tick();
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_valid", {31'b0, valid_d}, 0);
    chk("rst_instr", instr_d, 0);
    chk("rst_pcd", pc_d, 0);
    chk("rst_misalign", {31'b0, fetch_misalign}, 0);

    // Release, IDLE then REQ; first fetch at 0x0.
    redirect_valid = 0; rst = 1;
    #1 chk("idle_pc_next", pc_next, 32'h0);
    chk("idle_req", {31'b0, imem_req}, 0);
    tick();
    #1 chk("req0_req", {31'b0, imem_req}, 1);
    chk("req0_addr", imem_addr, 32'h0);
    chk("req0_hold", pc_next, 32'h0);
    tick();
    imem_gnt = 1;
    #1 chk("gnt0_pc_next", pc_next, 32'h4);
    tick();
    imem_gnt = 0;
    #1 chk("wait0_req", {31'b0, imem_req}, 0);
    chk("wait0_hold", pc_next, 32'h4);
    imem_rvalid = 1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 0;
    chk("ld0_instr", instr_d, 32'h0050_0093);
    chk("ld0_pcd", pc_d, 32'h0);
    chk("ld0_valid", {31'b0, valid_d}, 1);

    // Stall from the first valid: second response goes to the skid buffer.
    stall = 1; imem_gnt = 1;
    #1 chk("req1_addr", imem_addr, 32'h4);
    chk("gnt1_pc_next", pc_next, 32'h8);
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0010_0113;
    tick();
    imem_rvalid = 0;
    #1 chk("full_valid_hold", {31'b0, valid_d}, 1);
    chk("full_instr_hold", instr_d, 32'h0050_0093);
    chk("full_req", {31'b0, imem_req}, 0);
    chk("full_pc_next", pc_next, 32'h8);
    tick();
    #1 chk("full2_req", {31'b0, imem_req}, 0);
    chk("full2_instr_hold", instr_d, 32'h0050_0093);
    stall = 0;
    tick();
    chk("skid_instr", instr_d, 32'h0010_0113);
    chk("skid_pcd", pc_d, 32'h4);
    chk("skid_valid", {31'b0, valid_d}, 1);

    // Grant withheld three cycles at 0x8.
    for (int i = 0; i < 3; i++) begin
      #1 chk("nogrant_pc_next", pc_next, 32'h8);
      chk("nogrant_req", {31'b0, imem_req}, 1);
      tick();
    end
    chk("drain_valid", {31'b0, valid_d}, 0);
    imem_gnt = 1;
    #1 chk("gnt3_pc_next", pc_next, 32'hC);
    tick();

    // Redirect in WAIT: in-flight data is discarded.
    imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h100;
    #1 chk("redir_wait_pc_next", pc_next, 32'h100);
    tick();
    redirect_valid = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1 chk("drop_wait_hold", pc_next, 32'h100);
    tick();
    imem_rvalid = 0;
    #1 chk("drop_valid", {31'b0, valid_d}, 0);
    chk("redir_req", {31'b0, imem_req}, 1);
    chk("redir_addr", imem_addr, 32'h100);

    // Redirect in REQ without grant to 0x20, then redirect together with grant.
    redirect_valid = 1; redirect_pc = 32'h20;
    #1 chk("redir_req_pc_next", pc_next, 32'h20);
    tick();
    imem_gnt = 1; redirect_pc = REDIR_B;
    #1 chk("addr20", imem_addr, 32'h20);
    chk("redir_gnt_pc_next", pc_next, 32'h100);
    tick();
    redirect_valid = 0; imem_gnt = 0;
    #1 chk("misalign_pulse", {31'b0, fetch_misalign}, MIS_EXP);
    chk("drop2_hold", pc_next, 32'h100);
    imem_rvalid = 1; imem_rdata = 32'hAAAA_0020;
    tick();
    imem_rvalid = 0;
    #1 chk("drop2_valid", {31'b0, valid_d}, 0);
    chk("drop2_addr", imem_addr, 32'h100);
    chk("misalign_clear", {31'b0, fetch_misalign}, 0);
    imem_gnt = 1;
    #1 chk("gnt100_pc_next", pc_next, 32'h104);
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_0100;
    tick();
    imem_rvalid = 0;
    chk("ld100_instr", instr_d, 32'h1111_0100);
    chk("ld100_pcd", pc_d, 32'h100);
    chk("ld100_valid", {31'b0, valid_d}, 1);

    // Reset asserted while waiting with PC=0xABCDEF00.
    redirect_valid = 1; redirect_pc = 32'hABCD_EEFC;
    tick();
    redirect_valid = 0; imem_gnt = 1;
    #1 chk("gnt_hi_pc_next", pc_next, 32'hABCD_EF00);
    tick();
    imem_gnt = 0;
    #1 chk("wait_hi_addr", imem_addr, 32'hABCD_EF00);
    rst = 0;
    #1 chk("rstm_pc_next", pc_next, 32'h0);
    chk("rstm_valid", {31'b0, valid_d}, 0);
    chk("rstm_req", {31'b0, imem_req}, 0);
    chk("rstm_addr", imem_addr, 32'h0);
    imem_rvalid = 1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    chk("rstm_rvalid_ignored", {31'b0, valid_d}, 0);
    rst = 1;
    tick();
    #1 chk("rel_valid", {31'b0, valid_d}, 0);
    chk("rel_addr", imem_addr, 32'h0);
    chk("rel_req", {31'b0, imem_req}, 1);
    tick();
    chk("rel_rvalid_ignored", {31'b0, valid_d}, 0);
    imem_rvalid = 0; imem_gnt = 1;
    #1 chk("rel_gnt_pc_next", pc_next, 32'h4);
    tick();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0050_0093;
    tick();
    imem_rvalid = 0;
    chk("rel_instr", instr_d, 32'h0050_0093);
    chk("rel_pcd", pc_d, 32'h0);
    chk("rel_valid_d", {31'b0, valid_d}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
